minimips_control: RTL and testbench

- Main control decoder for the MiniMIPS single-issue datapath; sits between instruction fetch/decode and the datapath muxes, register file, ALU control and data memory.
- Decodes the 4-bit instruction opcode into seven 1-bit datapath control strobes and a 3-bit ALUOp code.
- All outputs are registered, one clock of latency. An illegal-opcode flag is also produced.

---
 rtl/minimips_control_pkg.sv | 47 ++++
 rtl/minimips_control_if.sv | 34 +++
 rtl/minimips_control_decode.sv | 75 +++++++
 rtl/minimips_control.sv | 45 ++++
 tb/tb_minimips_control.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/minimips_control_pkg.sv
// -----------------------------------------------------------------------------
// minimips_pkg
// Shared definitions for the MiniMIPS main control decoder. It holds the opcode
// and ALUOp encodings and the packed control-word struct that the decoder
// produces and the top level registers.
// -----------------------------------------------------------------------------
package minimips_pkg;

  localparam int OPC_W   = 4;
  localparam int ALUOP_W = 3;

  // Opcode encodings
  localparam logic [OPC_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ANDI  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ORI   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_NORI  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_BEQ   = 4'b0101;
  localparam logic [OPC_W-1:0] OP_BNE   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLTI  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_LW    = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SW    = 4'b1001;

  // ALU operation classes consumed by ALU control
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_AND   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_NOR   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b101;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALUOP_SUBNE = 3'b111;

  // Full control word. The all-zero value is the reset state.
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
  } ctrl_t;

endpackage

// File: rtl/minimips_control_if.sv
// -----------------------------------------------------------------------------
// minimips_control_if
// Bundles the decode request (en, Opcode) and the registered control strobes.
//   master : drives en/Opcode, observes the control outputs (fetch/decode side)
//   slave  : the control decoder itself
// -----------------------------------------------------------------------------
interface minimips_control_if;
  import minimips_pkg::*;

  logic               en;
  logic [OPC_W-1:0]   Opcode;
  logic               RegDst;
  logic               ALUSrc;
  logic               MemtoReg;
  logic               RegWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               Branch;
  logic [ALUOP_W-1:0] ALUOp;
  logic               Illegal;

  modport master (
    output en, Opcode,
    input  RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, Illegal
  );

  modport slave (
    input  en, Opcode,
    output RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
           ALUOp, Illegal
  );

endinterface

// File: rtl/minimips_control_decode.sv
// -----------------------------------------------------------------------------
// minimips_ctrl_decode
// Purely combinational opcode-to-control-word decoder.
//   opcode_i : instruction opcode field
//   ctrl_o   : decoded strobes, ALUOp class and illegal flag
// Any opcode outside the table (including X/Z) falls to the default arm, which
// yields a safe NOP with the illegal flag raised.
// -----------------------------------------------------------------------------
module minimips_ctrl_decode
  import minimips_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output ctrl_t            ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_ANDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_AND;
      end
      OP_ORI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_OR;
      end
      OP_NORI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_NOR;
      end
      OP_BEQ: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.alu_op    = ALUOP_SUBNE;
      end
      OP_SLTI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_SLT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/minimips_control.sv
// -----------------------------------------------------------------------------
// minimips_control
// MiniMIPS main control unit: decodes the opcode and registers the resulting
// control word with one clock of latency.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; clears every output
//   ctrl  : slave side of minimips_control_if (en, Opcode in; RegDst, ALUSrc,
//           MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal out)
// With en low the register holds, stalling the control word in place.
// -----------------------------------------------------------------------------
module minimips_control
  import minimips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  minimips_control_if.slave   ctrl
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  minimips_ctrl_decode u_decode (
    .opcode_i (ctrl.Opcode),
    .ctrl_o   (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else if (ctrl.en) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl.RegDst   = ctrl_q.reg_dst;
  assign ctrl.ALUSrc   = ctrl_q.alu_src;
  assign ctrl.MemtoReg = ctrl_q.mem_to_reg;
  assign ctrl.RegWrite = ctrl_q.reg_write;
  assign ctrl.MemRead  = ctrl_q.mem_read;
  assign ctrl.MemWrite = ctrl_q.mem_write;
  assign ctrl.Branch   = ctrl_q.branch;
  assign ctrl.ALUOp    = ctrl_q.alu_op;
  assign ctrl.Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_minimips_control.sv
// -----------------------------------------------------------------------------
// tb_minimips_control
// Directed, table-driven bench for minimips_control. Output word layout used
// throughout: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
// ALUOp[2:0], Illegal}.
// -----------------------------------------------------------------------------
module tb_minimips_control;

  typedef struct {
    logic [3:0]  op;
    logic [10:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vec_t        vecs [16];
  logic [10:0] exp_q;

  minimips_control_if bus ();

  minimips_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] dut_out();
    return {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
            bus.MemWrite, bus.Branch, bus.ALUOp, bus.Illegal};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One enabled decode: drive at negedge, sample at the following negedge.
  task automatic step(input logic [3:0] op, input logic en);
    bus.Opcode = op;
    bus.en     = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] got;
    checks = 0;
    errors = 0;

    // Hand-computed decode table
    vecs[0]  = '{4'b0000, 11'b1001000_000_0};
    vecs[1]  = '{4'b0001, 11'b0101000_001_0};
    vecs[2]  = '{4'b0010, 11'b0101000_010_0};
    vecs[3]  = '{4'b0011, 11'b0101000_011_0};
    vecs[4]  = '{4'b0100, 11'b0101000_100_0};
    vecs[5]  = '{4'b0101, 11'b0000001_101_0};
    vecs[6]  = '{4'b0110, 11'b0000001_111_0};
    vecs[7]  = '{4'b0111, 11'b0101000_110_0};
    vecs[8]  = '{4'b1000, 11'b0111100_001_0};
    vecs[9]  = '{4'b1001, 11'b0100010_001_0};
    for (int i = 10; i < 16; i++) vecs[i] = '{4'(i), 11'b0000000_000_1};

    // Reset held with clock running
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.Opcode = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", dut_out(), 11'd0);
    rst_n = 1'b1;

    // Full sweep, legal and illegal opcodes
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].op, 1'b1);
      check($sformatf("sweep_op%0d", i), dut_out(), vecs[i].exp);
    end

    // Back to addi from the illegal range
    step(4'b0001, 1'b1);
    check("illegal_to_addi", dut_out(), 11'b0101000_001_0);

    // Stall: lw held while en is low and Opcode shows sw
    step(4'b1000, 1'b1);
    check("stall_lw_load", dut_out(), vecs[8].exp);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 1'b0);
      check($sformatf("stall_hold%0d", i), dut_out(), vecs[8].exp);
    end
    step(4'b1001, 1'b1);
    check("stall_release_sw", dut_out(), vecs[9].exp);
    exp_q = vecs[9].exp;

    // Random opcode/en traffic with model and invariants
    for (int i = 0; i < 1000; i++) begin
      logic [3:0] op;
      logic       en;
      op = 4'($urandom_range(0, 15));
      en = ($urandom_range(0, 3) != 0);
      step(op, en);
      if (en) exp_q = vecs[op].exp;
      got = dut_out();
      check($sformatf("rand%0d", i), got, exp_q);
      check_bit("inv_rd_wr", bus.MemRead & bus.MemWrite, 1'b0);
      check_bit("inv_regwrite", bus.RegWrite & (bus.Branch | bus.MemWrite), 1'b0);
    end

    // Asynchronous reset between edges after an lw decode
    step(4'b1000, 1'b1);
    check("async_pre_lw", dut_out(), vecs[8].exp);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_clear", dut_out(), 11'd0);
    @(posedge clk);
    @(negedge clk);
    check("async_reset_hold", dut_out(), 11'd0);
    rst_n = 1'b1;
    step(4'b0110, 1'b1);
    check("post_reset_bne", dut_out(), vecs[6].exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
